mips_main_control: RTL and testbench
====================================

# mips_main_control

Multicycle MIPS main control unit: a Moore FSM that sequences each instruction through fetch, decode, execute, memory and write-back. It decodes the 6-bit opcode from the instruction register and drives all datapath enables and mux selects. It also generates the 2-bit `OpALU` code that the ALU control stage combines with `funct` to select the ALU operation. It sits directly upstream of the ALU control and adds a memory-ready handshake for variable-latency memory.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `opcode`  in  6  instr[31:26] from IR; must be stable from DECODE until instruction end
- `mem_ready`  in  1  memory completes the current access this cycle
- `PCWrite`  out  1  unconditional PC load
- `PCWriteCond`  out  1  PC load if ALU zero (branch)
- `IorD`  out  1  memory address select: 0 = PC, 1 = ALUOut
- `MemRead`  out  1  memory read request
- `MemWrite`  out  1  memory write request
- `IRWrite`  out  1  IR load
- `MemtoReg`  out  1  write-back select: 1 = MDR, 0 = ALUOut
- `RegDst`  out  1  destination select: 1 = rd, 0 = rt
- `RegWrite`  out  1  register file write
- `ALUSrcA`  out  1  0 = PC, 1 = A
- `ALUSrcB`  out  2  00 = B, 01 = const 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `OpALU`  out  2  00 = add, 01 = subtract, 10 = use funct
- `state`  out  4  current state code (debug)
- `illegal_op`  out  1  unsupported opcode seen in DECODE
- `instr_done`  out  1  last cycle of an instruction

## Operation
- Opcodes supported:
  - R-type `000000`
  - lw `100011`
  - sw `101011`
  - beq `000100`
  - j `000010`
  - addi `001000` (macro-gated, see Configuration)
- State codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11.
- Outputs decode from state combinationally; any output not listed for a state is 0.
- FETCH:
  - Outputs: MemRead=1, ALUSrcB=01, OpALU=00.
  - IRWrite = PCWrite = mem_ready.
  - Stay while mem_ready=0; go to DECODE on mem_ready=1.
- DECODE:
  - Outputs: ALUSrcB=11, OpALU=00 (branch target into ALUOut).
  - Next state: lw/sw → MEMADR; R → EXEC; beq → BRANCH; j → JUMP; addi → ADDIEX.
  - Other opcodes → FETCH, with illegal_op=1 and instr_done=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, OpALU=00. Next: lw → MEMRD, sw → MEMWR.
- MEMRD: MemRead=1, IorD=1. Stay until mem_ready, then MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0; instr_done=1; next FETCH.
- MEMWR: MemWrite=1, IorD=1. Stay until mem_ready; on mem_ready assert instr_done and go to FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, OpALU=10. Next ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0; instr_done=1; next FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, OpALU=01, PCWriteCond=1, PCSource=01; instr_done=1; next FETCH.
- JUMP: PCWrite=1, PCSource=10; instr_done=1; next FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, OpALU=00. Next ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0; instr_done=1; next FETCH.
- Unused state codes 12–15 → FETCH next cycle; all outputs 0.

## Timing
- Reset:
  - `rst`=1 at a rising edge loads FETCH.
  - While `rst` is high, every output is forced to 0, `state` included.
  - Reset mid-instruction aborts it; no write strobe is asserted in the reset cycle.
- Instruction latency in cycles with mem_ready held high:
  - lw 5; sw 4; R 4; addi 4; beq 3; j 3; illegal 2.
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle.
- Request outputs (MemRead/MemWrite/IorD) stay constant while waiting.
- mem_ready outside FETCH, MEMRD and MEMWR is ignored.
- instr_done is high exactly one cycle per instruction; the next cycle is FETCH.

## Configuration
- `MC_ADDI_EN` defined: addi is supported via ADDIEX/ADDIWB.
- `MC_ADDI_EN` undefined:
  - opcode `001000` is illegal (illegal_op=1 in DECODE, return to FETCH).
  - States 9 and 10 are unreachable and behave as unused codes.

## Structure
- Package `mips_ctrl_pkg` holds:
  - state code constants;
  - opcode constants;
  - OpALU codes (ADD 00, SUB 01, FUNCT 10);
  - ALUSrcB and PCSource select constants.
- The FSM (state register + next-state logic) lives in `mips_main_control`.
- One sub-module, `mc_output_decode`, maps state (plus mem_ready) to the control word.

## Test plan
- Reset: `rst`=1 for 2 cycles mid-lw (in MEMRD), then release → all outputs 0 during reset; state=0 and MemRead=1 on the first cycle after.
- lw `100011`, mem_ready=1 → state sequence 0,1,2,3,4; RegWrite=1 with MemtoReg=1 in cycle 5; instr_done only in cycle 5.
- R-type `000000` → OpALU=10 in EXEC; ALUWB has RegDst=1, RegWrite=1; 4 cycles total.
- sw `101011` with mem_ready low for 3 cycles in MEMWR → MemWrite=1, IorD=1 held for 4 cycles; total 7 cycles; no RegWrite.
- beq `000100` then j `000010` → BRANCH has OpALU=01, PCWriteCond=1, PCSource=01; JUMP has PCWrite=1, PCSource=10; 3 cycles each.
- opcode `001000`:
  - with `MC_ADDI_EN`: 4 cycles, ADDIWB RegWrite=1, RegDst=0.
  - without it: illegal_op=1 in DECODE, back to FETCH, no RegWrite.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main control: state codes, opcodes,
// ALU/mux select constants and the packed control word.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B      = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] op_alu;
        logic       instr_done;
    } ctrl_t;

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decode: maps the current state (and mem_ready for the memory
// handshake states) to the datapath control word. Macro MC_ADDI_EN enables addi states.
module mc_output_decode
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl           = '0;
        ctrl.alu_src_b = SRCB_B;
        ctrl.pc_source = PCSRC_ALU;
        ctrl.op_alu    = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
                ctrl.alu_src_b = SRCB_FOUR;
            end
            S_DECODE: begin
                ctrl.alu_src_b = SRCB_IMM_SH;
            end
            S_MEMADR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.i_or_d   = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write  = 1'b1;
                ctrl.i_or_d     = 1'b1;
                ctrl.instr_done = mem_ready;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.op_alu    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.reg_dst    = 1'b1;
                ctrl.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a     = 1'b1;
                ctrl.op_alu        = ALUOP_SUB;
                ctrl.pc_write_cond = 1'b1;
                ctrl.pc_source     = PCSRC_ALUOUT;
                ctrl.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl.pc_write   = 1'b1;
                ctrl.pc_source  = PCSRC_JUMP;
                ctrl.instr_done = 1'b1;
            end
`ifdef MC_ADDI_EN
            S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_ADDIWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.instr_done = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control FSM with memory-ready handshake.
// Optional addi support is enabled by defining MC_ADDI_EN.
module mips_main_control
    import mips_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] OpALU,
    output logic [3:0] state,
    output logic       illegal_op,
    output logic       instr_done
);

    state_t state_q;
    state_t state_d;
    logic   dec_illegal;
    ctrl_t  raw_ctrl;
    ctrl_t  ctrl;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d     = S_FETCH;
        dec_illegal = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default:      dec_illegal = 1'b1;
                endcase
            end
            S_MEMADR: state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
`ifdef MC_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    mc_output_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .ctrl      (raw_ctrl)
    );

    // Reset blanks every output combinationally so no strobe leaks in the reset cycle.
    always_comb begin
        ctrl = raw_ctrl;
        if (rst) ctrl = '0;
    end

    assign PCWrite     = ctrl.pc_write;
    assign PCWriteCond = ctrl.pc_write_cond;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign IRWrite     = ctrl.ir_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign PCSource    = ctrl.pc_source;
    assign OpALU       = ctrl.op_alu;
    assign state       = rst ? 4'd0 : state_q;
    assign illegal_op  = dec_illegal & ~rst;
    assign instr_done  = ctrl.instr_done | illegal_op;

endmodule

// File: tb/tb_mips_main_control.sv
// Scoreboard bench for mips_main_control: a driver pushes hand-computed
// control words per cycle, a monitor pops and compares them at the falling edge.
module tb_mips_main_control;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] opcode = 6'b0;
    logic       mem_ready = 1'b0;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, PCSource, OpALU;
    logic [3:0] state;
    logic       illegal_op, instr_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [21:0] word;
        string       tag;
    } exp_t;

    exp_t sb[$];

    // Word layout: PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,
    // RegWrite,ALUSrcA,ALUSrcB,PCSource,OpALU,state,illegal_op,instr_done
    localparam logic [21:0] W_ZERO      = 22'b0;
    localparam logic [21:0] W_FETCH_RDY = {10'b1001010000, 2'b01, 2'b00, 2'b00, 4'd0,  2'b00};
    localparam logic [21:0] W_FETCH_WT  = {10'b0001000000, 2'b01, 2'b00, 2'b00, 4'd0,  2'b00};
    localparam logic [21:0] W_DECODE    = {10'b0000000000, 2'b11, 2'b00, 2'b00, 4'd1,  2'b00};
    localparam logic [21:0] W_DEC_ILL   = {10'b0000000000, 2'b11, 2'b00, 2'b00, 4'd1,  2'b11};
    localparam logic [21:0] W_MEMADR    = {10'b0000000001, 2'b10, 2'b00, 2'b00, 4'd2,  2'b00};
    localparam logic [21:0] W_MEMRD     = {10'b0011000000, 2'b00, 2'b00, 2'b00, 4'd3,  2'b00};
    localparam logic [21:0] W_MEMWB     = {10'b0000001010, 2'b00, 2'b00, 2'b00, 4'd4,  2'b01};
    localparam logic [21:0] W_MEMWR_WT  = {10'b0010100000, 2'b00, 2'b00, 2'b00, 4'd5,  2'b00};
    localparam logic [21:0] W_MEMWR_RDY = {10'b0010100000, 2'b00, 2'b00, 2'b00, 4'd5,  2'b01};
    localparam logic [21:0] W_EXEC      = {10'b0000000001, 2'b00, 2'b00, 2'b10, 4'd6,  2'b00};
    localparam logic [21:0] W_ALUWB     = {10'b0000000110, 2'b00, 2'b00, 2'b00, 4'd7,  2'b01};
    localparam logic [21:0] W_BRANCH    = {10'b0100000001, 2'b00, 2'b01, 2'b01, 4'd8,  2'b01};
    localparam logic [21:0] W_JUMP      = {10'b1000000000, 2'b00, 2'b10, 2'b00, 4'd11, 2'b01};
    localparam logic [21:0] W_ADDIEX    = {10'b0000000001, 2'b10, 2'b00, 2'b00, 4'd9,  2'b00};
    localparam logic [21:0] W_ADDIWB    = {10'b0000000010, 2'b00, 2'b00, 2'b00, 4'd10, 2'b01};

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] JMP  = 6'b000010;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] BAD  = 6'b111111;

    mips_main_control dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWrite     (PCWrite),
        .PCWriteCond (PCWriteCond),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .IRWrite     (IRWrite),
        .MemtoReg    (MemtoReg),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .PCSource    (PCSource),
        .OpALU       (OpALU),
        .state       (state),
        .illegal_op  (illegal_op),
        .instr_done  (instr_done)
    );

    always #5 clk = ~clk;

    task automatic apply_stimulus(input logic [5:0] op, input logic mr, input logic rs,
                                  input logic [21:0] exp_word, input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        opcode    = op;
        mem_ready = mr;
        rst       = rs;
        e.word    = exp_word;
        e.tag     = tag;
        sb.push_back(e);
    endtask

    task automatic check_output(input exp_t e);
        logic [21:0] act;
        act = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
               RegWrite, ALUSrcA, ALUSrcB, PCSource, OpALU, state, illegal_op, instr_done};
        checks++;
        if (act !== e.word) begin
            errors++;
            $display("[TB] FAIL %s: got %b expected %b", e.tag, act, e.word);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) check_output(sb.pop_front());
    end

    initial begin
        apply_stimulus(RT, 1'b1, 1'b1, W_ZERO, "reset0");
        apply_stimulus(RT, 1'b1, 1'b1, W_ZERO, "reset1");

        apply_stimulus(LW, 1'b1, 1'b0, W_FETCH_RDY, "lw_fetch");
        apply_stimulus(LW, 1'b1, 1'b0, W_DECODE,    "lw_decode");
        apply_stimulus(LW, 1'b1, 1'b0, W_MEMADR,    "lw_memadr");
        apply_stimulus(LW, 1'b1, 1'b0, W_MEMRD,     "lw_memrd");
        apply_stimulus(LW, 1'b1, 1'b0, W_MEMWB,     "lw_memwb");

        apply_stimulus(RT, 1'b1, 1'b0, W_FETCH_RDY, "r_fetch");
        apply_stimulus(RT, 1'b0, 1'b0, W_DECODE,    "r_decode");
        apply_stimulus(RT, 1'b0, 1'b0, W_EXEC,      "r_exec");
        apply_stimulus(RT, 1'b1, 1'b0, W_ALUWB,     "r_aluwb");

        apply_stimulus(SW, 1'b1, 1'b0, W_FETCH_RDY, "sw_fetch");
        apply_stimulus(SW, 1'b1, 1'b0, W_DECODE,    "sw_decode");
        apply_stimulus(SW, 1'b1, 1'b0, W_MEMADR,    "sw_memadr");
        for (int i = 0; i < 3; i++)
            apply_stimulus(SW, 1'b0, 1'b0, W_MEMWR_WT, "sw_memwr_wait");
        apply_stimulus(SW, 1'b1, 1'b0, W_MEMWR_RDY, "sw_memwr_done");

        apply_stimulus(BEQ, 1'b1, 1'b0, W_FETCH_RDY, "beq_fetch");
        apply_stimulus(BEQ, 1'b1, 1'b0, W_DECODE,    "beq_decode");
        apply_stimulus(BEQ, 1'b1, 1'b0, W_BRANCH,    "beq_branch");
        apply_stimulus(JMP, 1'b1, 1'b0, W_FETCH_RDY, "j_fetch");
        apply_stimulus(JMP, 1'b1, 1'b0, W_DECODE,    "j_decode");
        apply_stimulus(JMP, 1'b1, 1'b0, W_JUMP,      "j_jump");

        apply_stimulus(LW, 1'b0, 1'b0, W_FETCH_WT,  "fetch_wait0");
        apply_stimulus(LW, 1'b0, 1'b0, W_FETCH_WT,  "fetch_wait1");
        apply_stimulus(LW, 1'b1, 1'b0, W_FETCH_RDY, "fetch_go");
        apply_stimulus(LW, 1'b1, 1'b0, W_DECODE,    "lw2_decode");
        apply_stimulus(LW, 1'b1, 1'b0, W_MEMADR,    "lw2_memadr");
        apply_stimulus(LW, 1'b0, 1'b0, W_MEMRD,     "lw2_memrd_wait");
        apply_stimulus(LW, 1'b0, 1'b1, W_ZERO,      "midlw_reset0");
        apply_stimulus(LW, 1'b1, 1'b1, W_ZERO,      "midlw_reset1");
        apply_stimulus(LW, 1'b1, 1'b0, W_FETCH_RDY, "post_reset_fetch");
        apply_stimulus(LW, 1'b1, 1'b0, W_DECODE,    "lw3_decode");
        apply_stimulus(LW, 1'b1, 1'b0, W_MEMADR,    "lw3_memadr");
        apply_stimulus(LW, 1'b0, 1'b0, W_MEMRD,     "lw3_memrd_wait");
        apply_stimulus(LW, 1'b1, 1'b0, W_MEMRD,     "lw3_memrd_rdy");
        apply_stimulus(LW, 1'b1, 1'b0, W_MEMWB,     "lw3_memwb");

        apply_stimulus(ADDI, 1'b1, 1'b0, W_FETCH_RDY, "addi_fetch");
`ifdef MC_ADDI_EN
        apply_stimulus(ADDI, 1'b1, 1'b0, W_DECODE,    "addi_decode");
        apply_stimulus(ADDI, 1'b1, 1'b0, W_ADDIEX,    "addi_ex");
        apply_stimulus(ADDI, 1'b1, 1'b0, W_ADDIWB,    "addi_wb");
`else
        apply_stimulus(ADDI, 1'b1, 1'b0, W_DEC_ILL,   "addi_illegal");
`endif
        apply_stimulus(BAD, 1'b1, 1'b0, W_FETCH_RDY, "bad_fetch");
        apply_stimulus(BAD, 1'b1, 1'b0, W_DEC_ILL,   "bad_illegal");
        apply_stimulus(BAD, 1'b0, 1'b0, W_FETCH_WT,  "bad_refetch");

        for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
